pr_timer: RTL and testbench
===========================

PR_TIMER -- requirements
Module: pr_timer

Interface
REQ-001 The block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-002 Port clk, input, 1 bit: rising-edge clock shared with the cpu core.
REQ-003 Port reset, input, 1 bit: synchronous reset, active when 0.
REQ-004 Port addr, input, 2 bits ([3:2] of the processor bus address): register select, where 0 = CTRL, 1 = PRESET, 2 = COUNT and 3 is reserved.
REQ-005 Port we, input, 1 bit: write strobe, already qualified by the bridge decode for this device.
REQ-006 Port be, input, 4 bits: byte-lane write enables taken from the processor bus byte enables.
REQ-007 Port wd, input, 32 bits: write data taken from the processor bus write data.
REQ-008 Port rd, output, 32 bits: combinational read data for the register selected by addr.
REQ-009 Port irq, output, 1 bit: interrupt request, wired to one bit of the cpu hardware-interrupt input.

Function
REQ-010 CTRL SHALL implement bit 0 EN (count enable), bits 2:1 MODE (0 = one-shot, 1 = auto-reload, 2 and 3 behave as 0) and bit 3 IM (interrupt mask); bits 31:4 SHALL read 0 and ignore writes.
REQ-011 A write SHALL update only the byte lanes whose be bit is 1; writes to COUNT and to the reserved address SHALL be ignored.
REQ-012 rd SHALL return CTRL, PRESET or COUNT according to addr, with zero latency, and SHALL return 0 for addr = 3.
REQ-013 The FSM SHALL have four states: IDLE, LOAD, CNT and INT.
REQ-014 In IDLE, if CTRL.EN = 1 the next state SHALL be LOAD; otherwise the FSM stays in IDLE.
REQ-015 In LOAD, COUNT SHALL be loaded with PRESET and the next state SHALL be CNT.
REQ-016 In CNT, if CTRL.EN = 0 the next state SHALL be IDLE with COUNT held; else if COUNT > 1, COUNT SHALL decrement by 1; else COUNT SHALL become 0, the next state SHALL be INT, and the internal flag IRQF SHALL be set.
REQ-017 In INT with MODE = 0, CTRL.EN SHALL be cleared and the next state SHALL be IDLE; IRQF SHALL stay set until any CTRL write, including a masked or partial-byte write.
REQ-018 In INT with MODE = 1, IRQF SHALL be cleared and the next state SHALL be LOAD, which yields a one-cycle IRQF pulse and a period of max(PRESET,1)+2 cycles.
REQ-019 irq SHALL equal IRQF AND CTRL.IM, with no extra register stage.
REQ-020 Latency: for a CTRL write that sets EN at edge E, the FSM SHALL be in LOAD after E+1, COUNT SHALL equal PRESET after E+2, and IRQF SHALL be set after E+2+max(PRESET,1).
REQ-021 PRESET = 0 SHALL behave as PRESET = 1 for timing, while COUNT reads 0.
REQ-022 A PRESET write during CNT SHALL NOT alter COUNT; it SHALL take effect at the next LOAD.
REQ-023 If a CTRL write coincides with the INT-state EN clear, the written EN value SHALL win.
REQ-024 If a CTRL write coincides with IRQF being set, the set SHALL win.
REQ-025 Arithmetic on COUNT SHALL be 32-bit unsigned and SHALL never wrap below 0.

Reset
REQ-026 When reset = 0 at a rising edge, CTRL, PRESET and COUNT SHALL become 0, IRQF SHALL become 0, the state SHALL become IDLE, and irq SHALL be 0 from the following cycle.
REQ-027 Reset SHALL take priority over any simultaneous write and over any mid-count state, including INT.
REQ-028 rd SHALL read 0 for every address after reset.

Verification
REQ-029 One-shot: write PRESET = 5, then CTRL = 0x9 at edge E -> COUNT reads 5 after E+2 and 1 after E+6; irq = 1 after E+7; CTRL reads 0x8 after E+8; irq stays 1 until the next CTRL write, after which it is 0.
REQ-030 Auto-reload: PRESET = 3, CTRL = 0xB at edge E -> irq is high for exactly one cycle after E+5, E+10 and E+15 (period 5).
REQ-031 Mask and abort: PRESET = 10, CTRL = 0x1, then CTRL = 0x0 written 4 cycles later -> COUNT freezes at its current value, the FSM returns to IDLE, and irq stays 0 throughout.
REQ-032 Byte lanes: PRESET = 0, then write wd = 0x11223344 with be = 0b0101 -> PRESET reads 0x00220044; writing COUNT leaves it unchanged; addr = 3 reads 0.
REQ-033 Reset mid-operation: PRESET = 8, CTRL = 0x9, then reset = 0 for one edge during CNT -> all registers read 0 and irq = 0, and no interrupt occurs afterwards.
REQ-034 Boundary: PRESET = 0, CTRL = 0x9 at edge E -> irq = 1 after E+3; a PRESET write during CNT does not change the current run.

Source files
------------

// File: rtl/pr_timer.sv
// pr_timer: memory-mapped down-counting timer with one-shot and auto-reload
// modes. Three registers (CTRL, PRESET, COUNT) sit behind a 2-bit word
// address. A four-state FSM (IDLE, LOAD, CNT, INT) sequences the count and
// raises an internal interrupt flag that is masked onto irq.
module pr_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } stateType;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  stateType    state;
  stateType    stateNext;

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irqf;

  logic        ctrlEn;
  logic        ctrlIm;
  logic        autoReload;
  logic        ctrlWr;
  logic        presetWr;

  // FSM action strobes
  logic        loadCount;
  logic        decCount;
  logic        zeroCount;
  logic        setIrq;
  logic        clrIrq;
  logic        clrEn;

  assign ctrlEn     = ctrl[0];
  assign ctrlIm     = ctrl[3];
  // MODE values 2 and 3 fall back to one-shot.
  assign autoReload = (ctrl[2:1] == 2'd1);
  assign ctrlWr     = we && (addr == ADDR_CTRL);
  assign presetWr   = we && (addr == ADDR_PRESET);

  // Merge write data into an existing word, one byte lane per be bit.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[i*8 +: 8] = newVal[i*8 +: 8];
    end
    return merged;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred.
    stateNext = state;
    case (state)
      IDLE: if (ctrlEn) stateNext = LOAD;
      LOAD: stateNext = CNT;
      CNT: begin
        if (!ctrlEn)         stateNext = IDLE;
        else if (count <= 1) stateNext = INT;
      end
      INT: stateNext = autoReload ? LOAD : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM output decode: one-cycle action strobes for the datapath
  always_comb begin
    loadCount = 1'b0;
    decCount  = 1'b0;
    zeroCount = 1'b0;
    setIrq    = 1'b0;
    clrIrq    = 1'b0;
    clrEn     = 1'b0;
    case (state)
      LOAD: loadCount = 1'b1;
      CNT: begin
        if (ctrlEn) begin
          if (count > 1) begin
            decCount = 1'b1;
          end else begin
            zeroCount = 1'b1;
            setIrq    = 1'b1;
          end
        end
      end
      INT: begin
        if (autoReload) clrIrq = 1'b1;
        else            clrEn  = 1'b1;
      end
      default: ;
    endcase
  end

  // CTRL register: only byte lane 0 carries implemented bits; a written EN
  // overrides the one-shot EN clear because the write is applied last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl <= 4'd0;
    end else begin
      if (clrEn) ctrl[0] <= 1'b0;
      if (ctrlWr && be[0]) ctrl <= wd[3:0];
    end
  end

  // PRESET register: byte-lane writes; COUNT picks it up only at LOAD
  always_ff @(posedge clk) begin
    if (!reset)        preset <= 32'd0;
    else if (presetWr) preset <= mergeBytes(preset, wd, be);
  end

  // COUNT register: load, decrement, or floor at zero; never written by the bus
  always_ff @(posedge clk) begin
    if (!reset)         count <= 32'd0;
    else if (loadCount) count <= preset;
    else if (decCount)  count <= count - 32'd1;
    else if (zeroCount) count <= 32'd0;
  end

  // Interrupt flag: setting beats a coincident CTRL-write clear
  always_ff @(posedge clk) begin
    if (!reset)                 irqf <= 1'b0;
    else if (setIrq)            irqf <= 1'b1;
    else if (clrIrq || ctrlWr)  irqf <= 1'b0;
  end

  // Zero-latency read mux
  always_comb begin
    rd = 32'd0;
    case (addr)
      ADDR_CTRL:   rd = {28'd0, ctrl};
      ADDR_PRESET: rd = preset;
      ADDR_COUNT:  rd = count;
      default:     rd = 32'd0;
    endcase
  end

  assign irq = irqf & ctrlIm;

endmodule

// File: tb/tb_pr_timer.sv
// Directed testbench for pr_timer. Inputs change on the falling edge; "after
// edge E+k" samples are taken 1 ns after the k-th rising edge following E.
module tb_pr_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int numChecks = 0;
  int numErrors = 0;

  pr_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .be    (be),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
    end
    #1;
  endtask

  // Bus write; the rising edge that captures it is "E" for the caller.
  task automatic writeReg(input logic [1:0] a, input logic [31:0] d, input logic [3:0] lanes);
    @(negedge clk);
    addr = a;
    wd   = d;
    be   = lanes;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
    be   = 4'h0;
  endtask

  task automatic readCheck(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    addr  = 2'd0;
    we    = 1'b0;
    be    = 4'h0;
    wd    = 32'd0;

    // Reset state
    doReset();
    readCheck("rst_ctrl", 2'd0, 32'd0);
    readCheck("rst_preset", 2'd1, 32'd0);
    readCheck("rst_count", 2'd2, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // One-shot: PRESET=5, CTRL=0x9
    writeReg(2'd1, 32'd5, 4'hF);
    writeReg(2'd0, 32'h9, 4'hF);               // E
    tick(2);
    readCheck("os_count_e2", 2'd2, 32'd5);
    tick(4);
    readCheck("os_count_e6", 2'd2, 32'd1);
    check("os_irq_e6", {31'd0, irq}, 32'd0);
    tick(1);
    check("os_irq_e7", {31'd0, irq}, 32'd1);
    readCheck("os_count_e7", 2'd2, 32'd0);
    tick(1);
    readCheck("os_ctrl_e8", 2'd0, 32'h8);
    check("os_irq_e8", {31'd0, irq}, 32'd1);
    tick(3);
    check("os_irq_hold", {31'd0, irq}, 32'd1);
    writeReg(2'd0, 32'h0, 4'h0);               // masked write still clears
    check("os_irq_clr", {31'd0, irq}, 32'd0);
    readCheck("os_ctrl_after", 2'd0, 32'h8);

    // Auto-reload: PRESET=3, CTRL=0xB -> pulses after E+5, E+10, E+15
    doReset();
    writeReg(2'd1, 32'd3, 4'hF);
    writeReg(2'd0, 32'hB, 4'hF);               // E
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      check($sformatf("ar_irq_e%0d", k), {31'd0, irq},
            (k == 5 || k == 10 || k == 15) ? 32'd1 : 32'd0);
    end
    writeReg(2'd0, 32'h0, 4'hF);

    // Mask and abort: PRESET=10, CTRL=0x1, CTRL=0x0 at E+4
    doReset();
    writeReg(2'd1, 32'd10, 4'hF);
    writeReg(2'd0, 32'h1, 4'hF);               // E
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      check($sformatf("ab_irq_e%0d", k), {31'd0, irq}, 32'd0);
    end
    writeReg(2'd0, 32'h0, 4'hF);               // E+4
    readCheck("ab_count_e4", 2'd2, 32'd8);
    tick(6);
    readCheck("ab_count_frozen", 2'd2, 32'd8);
    check("ab_irq", {31'd0, irq}, 32'd0);

    // Byte lanes, COUNT write ignored, reserved address
    doReset();
    writeReg(2'd1, 32'd0, 4'hF);
    writeReg(2'd1, 32'h11223344, 4'b0101);
    readCheck("bl_preset", 2'd1, 32'h00220044);
    writeReg(2'd2, 32'hFFFFFFFF, 4'hF);
    readCheck("bl_count_ro", 2'd2, 32'd0);
    writeReg(2'd3, 32'hFFFFFFFF, 4'hF);
    readCheck("bl_addr3", 2'd3, 32'd0);
    writeReg(2'd0, 32'hFFFFFFF6, 4'hF);
    readCheck("bl_ctrl_hi", 2'd0, 32'h6);
    writeReg(2'd0, 32'h0000000F, 4'b1110);
    readCheck("bl_ctrl_lane", 2'd0, 32'h6);

    // Reset mid-count, with a coincident CTRL write
    doReset();
    writeReg(2'd1, 32'd8, 4'hF);
    writeReg(2'd0, 32'h9, 4'hF);               // E
    tick(4);
    readCheck("rm_count_e4", 2'd2, 32'd6);
    @(negedge clk);
    reset = 1'b0;
    addr  = 2'd0;
    wd    = 32'h9;
    be    = 4'hF;
    we    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    we    = 1'b0;
    be    = 4'h0;
    readCheck("rm_ctrl", 2'd0, 32'd0);
    readCheck("rm_preset", 2'd1, 32'd0);
    readCheck("rm_count", 2'd2, 32'd0);
    check("rm_irq", {31'd0, irq}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(5);
      check($sformatf("rm_irq_later%0d", k), {31'd0, irq}, 32'd0);
    end
    readCheck("rm_count_later", 2'd2, 32'd0);

    // Boundary: PRESET=0 behaves as 1
    doReset();
    writeReg(2'd1, 32'd0, 4'hF);
    writeReg(2'd0, 32'h9, 4'hF);               // E
    tick(2);
    readCheck("p0_count_e2", 2'd2, 32'd0);
    check("p0_irq_e2", {31'd0, irq}, 32'd0);
    tick(1);
    check("p0_irq_e3", {31'd0, irq}, 32'd1);

    // PRESET write during CNT leaves the current run alone
    doReset();
    writeReg(2'd1, 32'd4, 4'hF);
    writeReg(2'd0, 32'h9, 4'hF);               // E
    tick(2);
    readCheck("pw_count_e2", 2'd2, 32'd4);
    writeReg(2'd1, 32'd100, 4'hF);             // E+3
    readCheck("pw_count_e3", 2'd2, 32'd3);
    readCheck("pw_preset", 2'd1, 32'd100);
    tick(2);
    check("pw_irq_e5", {31'd0, irq}, 32'd0);
    readCheck("pw_count_e5", 2'd2, 32'd1);
    tick(1);
    check("pw_irq_e6", {31'd0, irq}, 32'd1);

    // Written EN beats the INT-state EN clear; IRQF set beats a CTRL-write clear
    doReset();
    writeReg(2'd1, 32'd2, 4'hF);
    writeReg(2'd0, 32'h9, 4'hF);               // E
    tick(4);
    check("cx_irq_e4", {31'd0, irq}, 32'd1);
    writeReg(2'd0, 32'h9, 4'hF);               // W = E+5, FSM in INT
    readCheck("cx_ctrl_w", 2'd0, 32'h9);
    check("cx_irq_w", {31'd0, irq}, 32'd0);
    tick(3);
    check("cx_irq_w3", {31'd0, irq}, 32'd0);
    writeReg(2'd0, 32'h9, 4'hF);               // W+4, IRQF set this edge
    check("cx_irq_set_wins", {31'd0, irq}, 32'd1);
    tick(1);
    readCheck("cx_ctrl_w5", 2'd0, 32'h8);
    check("cx_irq_w5", {31'd0, irq}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
